// File: rtl/qcs_dyn_pre_gen_pkg.sv
// Shared types, amplitude and tone tables for the pre-generated STF/LTF response path.
package qcs_dyn_pre_gen_pkg;

    typedef enum logic [1:0] {GammaP1 = 2'd0, GammaPj = 2'd1, GammaM1 = 2'd2, GammaMj = 2'd3} gamma_e;
    typedef enum logic [1:0] {Bw20 = 2'd0, Bw40 = 2'd1, Bw80 = 2'd2, BwRsvd = 2'd3} bw_e;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int          AMP        = 1 << (DATA_W_DEF - 2);

    // Bit {subband, tone}: *_NZ marks a populated tone, *_NEG marks a -1 component.
    // LTF is real-valued, so it carries no Q tables.
    localparam logic [255:0] STF_NZ    = {4{64'h1111_1111_1111_1110}};
    localparam logic [255:0] STF_I_NEG =
        256'hA5C3_0F96_3C5A_E187_5A3C_F069_C3A5_1E78_9696_3C3C_0FF0_A55A_6969_C3C3_F00F_5AA5;
    localparam logic [255:0] STF_Q_NEG =
        256'h3C96_A50F_C369_5AE1_96A5_0FC3_69F0_E15A_5A5A_9696_C30F_3CA5_A5A5_6969_0F3C_C35A;
    localparam logic [255:0] LTF_NZ    = {4{64'hFFFF_FFC0_07FF_FFFE}};
    localparam logic [255:0] LTF_I_NEG =
        256'h6D2B_91E4_C75A_083F_B1E9_4D26_7A0C_F358_2E94_D6B1_05F7_8AC3_9B4E_21D7_C68F_3A50;

    function automatic logic cfg_invalid(input int unsigned bw, input int unsigned sys_bw,
                                         input int unsigned ntx);
        return (bw == 32'(BwRsvd)) || (bw > sys_bw) || (ntx == 0) || (ntx > 8);
    endfunction

endpackage

// File: rtl/qcs_dyn_pre_gen_rsp_if.sv
// Read request / sample response bundle between the sample consumer and the response block.
interface qcs_dyn_pre_gen_rsp_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 12
);
    logic                     nhtp_ltf;
    logic                     nhtp_re;
    logic [ADDR_W-1:0]        nhtp_raddr;
    logic                     rsp_valid;
    logic signed [DATA_W-1:0] rsp_i;
    logic signed [DATA_W-1:0] rsp_q;
    logic [ADDR_W-1:0]        rsp_addr;
    logic [7:0]               rsp_lane_en;
    logic                     busy;

    modport master (
        output nhtp_ltf, nhtp_re, nhtp_raddr,
        input  rsp_valid, rsp_i, rsp_q, rsp_addr, rsp_lane_en, busy
    );

    modport slave (
        input  nhtp_ltf, nhtp_re, nhtp_raddr,
        output rsp_valid, rsp_i, rsp_q, rsp_addr, rsp_lane_en, busy
    );
endinterface

// File: rtl/qcs_dyn_pre_gen_rom.sv
// Pre-generated STF/LTF tone store: {table, subband, tone} -> I/Q of 0 or +/-AMP,
// registered read with one cycle of latency.
module qcs_dyn_pre_gen_rom
    import qcs_dyn_pre_gen_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int          AMP_VAL = AMP
) (
    input  logic                     clk,
    input  logic [8:0]               idx,
    output logic signed [DATA_W-1:0] rd_i,
    output logic signed [DATA_W-1:0] rd_q
);
    localparam logic signed [DATA_W-1:0] POS = DATA_W'(AMP_VAL);
    localparam logic signed [DATA_W-1:0] NEG = DATA_W'(-AMP_VAL);

    logic [7:0] sel;
    logic       nz_i, neg_i, nz_q, neg_q;

    always_comb begin
        sel = idx[7:0];
        if (idx[8]) begin
            nz_i  = LTF_NZ[sel];
            neg_i = LTF_I_NEG[sel];
            nz_q  = 1'b0;
            neg_q = 1'b0;
        end else begin
            nz_i  = STF_NZ[sel];
            neg_i = STF_I_NEG[sel];
            nz_q  = STF_NZ[sel];
            neg_q = STF_Q_NEG[sel];
        end
    end

    always_ff @(posedge clk) begin
        rd_i <= nz_i ? (neg_i ? NEG : POS) : '0;
        rd_q <= nz_q ? (neg_q ? NEG : POS) : '0;
    end

endmodule

// File: rtl/qcs_dyn_pre_gen_rsp.sv
// Response pipeline for pre-generated STF/LTF samples: per-burst config latch, ROM lookup,
// gamma rotation and subband masking over three register stages.
module qcs_dyn_pre_gen_rsp
    import qcs_dyn_pre_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BW_W      = 2,
    parameter int unsigned SUBBAND_W = 4,
    parameter int unsigned GAMMA_W   = 8,
    parameter int unsigned DATA_W    = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    qcs_dyn_pre_gen_rsp_if.slave bus,
    input  logic [BW_W-1:0]      txconfig_bw,
    input  logic [BW_W-1:0]      sys_bw_mode,
    input  logic [SUBBAND_W-1:0] config_mu_subband_present,
    input  logic [GAMMA_W-1:0]   config_gamma_rotation,
    input  logic [3:0]           n_tx,
    input  logic                 nhtp_4ch,
    output logic                 cfg_err
);
    localparam int unsigned SB_W = ADDR_W - 6;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e               state_q;
    logic                 cfg_err_q, ltf_q, dup_q;
    logic [BW_W-1:0]      bw_q;
    logic [SUBBAND_W-1:0] mask_q;
    logic [GAMMA_W-1:0]   gamma_q;
    logic [7:0]           lane_q;

    logic                 start, bad_cfg, cur_ltf, cur_dup, cur_err;
    logic [7:0]           lane_new, cur_lane;
    logic [BW_W-1:0]      cur_bw;
    logic [SUBBAND_W-1:0] cur_mask;
    logic [GAMMA_W-1:0]   cur_gamma;

    // The burst's first request sees the live config; later ones see the latched copy.
    assign start     = (state_q == StIdle) && bus.nhtp_re;
    assign bad_cfg   = cfg_invalid(32'(txconfig_bw), 32'(sys_bw_mode), 32'(n_tx));
    assign lane_new  = bad_cfg ? 8'h00 : 8'((9'd1 << n_tx) - 9'd1);
    assign cur_ltf   = start ? bus.nhtp_ltf : ltf_q;
    assign cur_dup   = start ? nhtp_4ch : dup_q;
    assign cur_err   = start ? bad_cfg : cfg_err_q;
    assign cur_bw    = start ? txconfig_bw : bw_q;
    assign cur_mask  = start ? config_mu_subband_present : mask_q;
    assign cur_gamma = start ? config_gamma_rotation : gamma_q;
    assign cur_lane  = start ? lane_new : lane_q;
    assign cfg_err   = cfg_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cfg_err_q <= 1'b0;
            ltf_q     <= 1'b0;
            dup_q     <= 1'b0;
            bw_q      <= '0;
            mask_q    <= '0;
            gamma_q   <= '0;
            lane_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (bus.nhtp_re) begin
                    state_q   <= StBurst;
                    cfg_err_q <= bad_cfg;
                    ltf_q     <= bus.nhtp_ltf;
                    dup_q     <= nhtp_4ch;
                    bw_q      <= txconfig_bw;
                    mask_q    <= config_mu_subband_present;
                    gamma_q   <= config_gamma_rotation;
                    lane_q    <= lane_new;
                end
                StBurst: if (!bus.nhtp_re) state_q <= StIdle;
            endcase
        end
    end

    logic [SB_W-1:0] req_sb;
    logic            sb_on, req_zero;
    gamma_e          req_gam;
    logic [8:0]      req_idx;

    always_comb begin
        req_sb  = bus.nhtp_raddr[ADDR_W-1:6];
        sb_on   = 1'b0;
        req_gam = GammaP1;
        for (int k = 0; k < int'(SUBBAND_W); k++) begin
            if (int'(req_sb) == k) begin
                sb_on   = cur_mask[k];
                req_gam = gamma_e'(cur_gamma[2*k +: 2]);
            end
        end
        req_zero = cur_err || !sb_on || (32'(req_sb) >= (32'd1 << cur_bw));
        // Duplicate mode reads subband 0 but keeps the requested subband's rotation.
        req_idx  = {cur_ltf, cur_dup ? 2'b00 : req_sb[1:0], bus.nhtp_raddr[5:0]};
    end

    logic                     s1_vld_q, s2_vld_q, s1_zero_q, s2_zero_q;
    logic [ADDR_W-1:0]        s1_addr_q, s2_addr_q;
    logic [8:0]               s1_idx_q;
    gamma_e                   s1_gam_q, s2_gam_q;
    logic [7:0]               s1_lane_q, s2_lane_q;
    logic signed [DATA_W-1:0] rom_i, rom_q, rot_i, rot_q;

    qcs_dyn_pre_gen_rom #(
        .DATA_W  (DATA_W),
        .AMP_VAL (1 << (DATA_W - 2))
    ) u_rom (
        .clk  (clk),
        .idx  (s1_idx_q),
        .rd_i (rom_i),
        .rd_q (rom_q)
    );

    function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
        return -x;
    endfunction

    always_comb begin
        rot_i = rom_i;
        rot_q = rom_q;
        unique case (s2_gam_q)
            GammaP1: begin rot_i = rom_i;          rot_q = rom_q;          end
            GammaPj: begin rot_i = neg_sat(rom_q); rot_q = rom_i;          end
            GammaM1: begin rot_i = neg_sat(rom_i); rot_q = neg_sat(rom_q); end
            GammaMj: begin rot_i = rom_q;          rot_q = neg_sat(rom_i); end
        endcase
    end

    logic                     rsp_valid_q;
    logic signed [DATA_W-1:0] rsp_i_q, rsp_q_q;
    logic [ADDR_W-1:0]        rsp_addr_q;
    logic [7:0]               rsp_lane_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_idx_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_gam_q    <= GammaP1;
            s1_lane_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_addr_q   <= '0;
            s2_zero_q   <= 1'b0;
            s2_gam_q    <= GammaP1;
            s2_lane_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_i_q     <= '0;
            rsp_q_q     <= '0;
            rsp_addr_q  <= '0;
            rsp_lane_q  <= '0;
        end else begin
            s1_vld_q    <= bus.nhtp_re;
            s1_addr_q   <= bus.nhtp_raddr;
            s1_idx_q    <= req_idx;
            s1_zero_q   <= req_zero;
            s1_gam_q    <= req_gam;
            s1_lane_q   <= cur_lane;
            s2_vld_q    <= s1_vld_q;
            s2_addr_q   <= s1_addr_q;
            s2_zero_q   <= s1_zero_q;
            s2_gam_q    <= s1_gam_q;
            s2_lane_q   <= s1_lane_q;
            rsp_valid_q <= s2_vld_q;
            rsp_addr_q  <= s2_vld_q ? s2_addr_q : '0;
            rsp_i_q     <= (s2_vld_q && !s2_zero_q) ? rot_i : '0;
            rsp_q_q     <= (s2_vld_q && !s2_zero_q) ? rot_q : '0;
            if (s2_vld_q) rsp_lane_q <= s2_lane_q;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_i       = rsp_i_q;
    assign bus.rsp_q       = rsp_q_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_lane_en = rsp_lane_q;
    assign bus.busy        = (state_q == StBurst) || s1_vld_q || s2_vld_q || rsp_valid_q;

endmodule
